// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 inverse cipher: one decryption round per clock, with the
// earlier round keys derived on the fly from the round-10 key.
module aes128_inv_cipher (
  input  logic         clock,
  input  logic         resetModule,
  input  logic [127:0] inputData,
  input  logic [127:0] key,
  input  logic         inputsLoadedFlag,
  output logic [127:0] outputData,
  output logic         dataDecryptedFlag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t         fsm_r, fsm_s;
  logic [127:0] state_r, state_s;
  logic [127:0] rk_r, rk_s;
  logic [3:0]   rnd_r, rnd_s;
  logic [127:0] out_r, out_s;
  logic         flag_r, flag_s;

  logic [127:0] isr_s, isb_s, ark_s, imc_s, rk_next_s;
  logic [31:0]  w0_s, w1_s, w2_s, w3_s, p0_s, p1_s, p2_s, p3_s, rot_s, sw_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? t : 8'h00);
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 = x^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
    logic [7:0] y;
    logic [7:0] v;
    logic [7:0] a;
    y = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
    v = gf_inv(y);
    a = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    return inv ? v : a;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd10:   c = 8'h36;
      4'd9:    c = 8'h1b;
      4'd8:    c = 8'h80;
      4'd7:    c = 8'h40;
      4'd6:    c = 8'h20;
      4'd5:    c = 8'h10;
      4'd4:    c = 8'h08;
      4'd3:    c = 8'h04;
      4'd2:    c = 8'h02;
      4'd1:    c = 8'h01;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Inverse key schedule: rk_r holds round key rnd_r, rk_next_s is round key rnd_r-1
  always_comb begin
    w0_s      = rk_r[127:96];
    w1_s      = rk_r[95:64];
    w2_s      = rk_r[63:32];
    w3_s      = rk_r[31:0];
    p3_s      = w3_s ^ w2_s;
    p2_s      = w2_s ^ w1_s;
    p1_s      = w1_s ^ w0_s;
    rot_s     = {p3_s[23:0], p3_s[31:24]};
    sw_s      = {sbox(rot_s[31:24], 1'b0), sbox(rot_s[23:16], 1'b0),
                 sbox(rot_s[15:8], 1'b0),  sbox(rot_s[7:0], 1'b0)};
    p0_s      = w0_s ^ sw_s ^ {rcon(rnd_r), 24'h000000};
    rk_next_s = {p0_s, p1_s, p2_s, p3_s};
  end

  // One inverse round: byte (r,c) lives at bits [127-8*(r+4c) -: 8]
  always_comb begin
    isr_s = 128'd0;
    isb_s = 128'd0;
    imc_s = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        isr_s[127-8*(r+4*c) -: 8] = state_r[127-8*(r+4*((c-r+4)%4)) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      isb_s[127-8*i -: 8] = sbox(isr_s[127-8*i -: 8], 1'b1);
    end
    ark_s = isb_s ^ rk_next_s;
    for (int c = 0; c < 4; c++) begin
      imc_s[127-32*c -: 8] = gf_mul(ark_s[127-32*c -: 8], 8'h0e) ^ gf_mul(ark_s[119-32*c -: 8], 8'h0b)
                           ^ gf_mul(ark_s[111-32*c -: 8], 8'h0d) ^ gf_mul(ark_s[103-32*c -: 8], 8'h09);
      imc_s[119-32*c -: 8] = gf_mul(ark_s[127-32*c -: 8], 8'h09) ^ gf_mul(ark_s[119-32*c -: 8], 8'h0e)
                           ^ gf_mul(ark_s[111-32*c -: 8], 8'h0b) ^ gf_mul(ark_s[103-32*c -: 8], 8'h0d);
      imc_s[111-32*c -: 8] = gf_mul(ark_s[127-32*c -: 8], 8'h0d) ^ gf_mul(ark_s[119-32*c -: 8], 8'h09)
                           ^ gf_mul(ark_s[111-32*c -: 8], 8'h0e) ^ gf_mul(ark_s[103-32*c -: 8], 8'h0b);
      imc_s[103-32*c -: 8] = gf_mul(ark_s[127-32*c -: 8], 8'h0b) ^ gf_mul(ark_s[119-32*c -: 8], 8'h0d)
                           ^ gf_mul(ark_s[111-32*c -: 8], 8'h09) ^ gf_mul(ark_s[103-32*c -: 8], 8'h0e);
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge resetModule) begin
    if (resetModule) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (inputsLoadedFlag) fsm_s = ROUND;
        else                  fsm_s = IDLE;
      end
      ROUND: begin
        if (rnd_r == 4'd1) fsm_s = DONE;
        else               fsm_s = ROUND;
      end
      DONE: begin
        if (!inputsLoadedFlag) fsm_s = IDLE;
        else                   fsm_s = DONE;
      end
      default: fsm_s = IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs
  always_comb begin
    state_s = state_r;
    rk_s    = rk_r;
    rnd_s   = rnd_r;
    out_s   = out_r;
    flag_s  = flag_r;
    case (fsm_r)
      IDLE: begin
        if (inputsLoadedFlag) begin
          state_s = inputData ^ key;
          rk_s    = key;
          rnd_s   = 4'd10;
        end else begin
          state_s = state_r;
        end
      end
      ROUND: begin
        rk_s = rk_next_s;
        if (rnd_r == 4'd1) begin
          state_s = ark_s;
          out_s   = ark_s;
          flag_s  = 1'b1;
        end else begin
          state_s = imc_s;
          rnd_s   = rnd_r - 4'd1;
        end
      end
      DONE: begin
        if (!inputsLoadedFlag) flag_s = 1'b0;
        else                   flag_s = flag_r;
      end
      default: flag_s = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge resetModule) begin
    if (resetModule) begin
      state_r <= 128'd0;
      rk_r    <= 128'd0;
      rnd_r   <= 4'd0;
      out_r   <= 128'd0;
      flag_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      rk_r    <= rk_s;
      rnd_r   <= rnd_s;
      out_r   <= out_s;
      flag_r  <= flag_s;
    end
  end

  assign outputData        = out_r;
  assign dataDecryptedFlag = flag_r;

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// Directed bench for aes128_inv_cipher using the FIPS-197 C.1 and App.B vectors.
module tb_aes128_inv_cipher;

  logic         clock = 1'b0;
  logic         resetModule;
  logic [127:0] inputData;
  logic [127:0] key;
  logic         inputsLoadedFlag;
  logic [127:0] outputData;
  logic         dataDecryptedFlag;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_inv_cipher dut (
    .clock            (clock),
    .resetModule      (resetModule),
    .inputData        (inputData),
    .key              (key),
    .inputsLoadedFlag (inputsLoadedFlag),
    .outputData       (outputData),
    .dataDecryptedFlag(dataDecryptedFlag)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [127:0] ct, input logic [127:0] k);
    @(negedge clock);
    inputData        = ct;
    key              = k;
    inputsLoadedFlag = 1'b1;
  endtask

  task automatic drop_flag();
    @(negedge clock);
    inputsLoadedFlag = 1'b0;
  endtask

  initial begin
    resetModule      = 1'b1;
    inputData        = 128'd0;
    key              = 128'd0;
    inputsLoadedFlag = 1'b0;
    tick(2);
    check_val("rst_out", outputData, 128'd0);
    check_val("rst_flag", {127'd0, dataDecryptedFlag}, 128'd0);
    @(negedge clock);
    resetModule = 1'b0;

    // Vector 1 after a long idle, with per-edge latency check
    tick(500);
    check_val("idle_flag", {127'd0, dataDecryptedFlag}, 128'd0);
    load(CT1, K1);
    for (int e = 0; e <= 10; e++) begin
      @(posedge clock);
      #1;
      check_val($sformatf("lat_e%0d", e), {127'd0, dataDecryptedFlag}, (e == 10) ? 128'd1 : 128'd0);
    end
    check_val("v1_out", outputData, PT1);

    // Flag held high: result must stay put with no rerun
    for (int k = 0; k < 10; k++) begin
      tick(100);
      check_val($sformatf("hold_out%0d", k), outputData, PT1);
      check_val($sformatf("hold_flag%0d", k), {127'd0, dataDecryptedFlag}, 128'd1);
    end

    // Back-to-back with vector 2
    drop_flag();
    tick(1);
    check_val("drop_flag", {127'd0, dataDecryptedFlag}, 128'd0);
    check_val("drop_out", outputData, PT1);
    load(CT2, K2);
    tick(10);
    check_val("v2_e9_flag", {127'd0, dataDecryptedFlag}, 128'd0);
    tick(1);
    check_val("v2_out", outputData, PT2);
    check_val("v2_flag", {127'd0, dataDecryptedFlag}, 128'd1);

    // Inputs altered mid-run must not affect the result
    drop_flag();
    tick(1);
    load(CT1, K1);
    tick(4);
    @(negedge clock);
    inputData = CT2 ^ 128'h1;
    key       = K2;
    tick(7);
    check_val("chg_out", outputData, PT1);
    check_val("chg_flag", {127'd0, dataDecryptedFlag}, 128'd1);

    // Asynchronous reset in the middle of a decryption
    drop_flag();
    tick(1);
    load(CT2, K2);
    tick(6);
    #2;
    resetModule = 1'b1;
    #1;
    check_val("arst_out", outputData, 128'd0);
    check_val("arst_flag", {127'd0, dataDecryptedFlag}, 128'd0);
    tick(2);
    check_val("arst_hold", outputData, 128'd0);
    @(negedge clock);
    resetModule = 1'b0;
    tick(11);
    check_val("post_rst_out", outputData, PT2);
    check_val("post_rst_flag", {127'd0, dataDecryptedFlag}, 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
